array_scan_sequencer: RTL
=========================

Name: array_scan_sequencer

Overview:
Sequences a WIDTH x DEPTH unpacked 2D array into a one-element-per-transfer valid/ready stream for monitor/checker instances. On a start pulse it snapshots the whole array, then emits elements index 0 to DEPTH-1 with index and last tags. It sits between the array producer and the monitor wrapper. It serialises a wide 2D interface so that one narrow checker can be shared across all entries.

Parameters:
- WIDTH, 8, bits per array element.
- DEPTH, 64, number of array elements; legal range >= 2.
- IDX_W, $clog2(DEPTH), width of index output; derived, do not override.

Ports:
- CLK  input  1  rising-edge clock.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- arr  input  [WIDTH-1:0] x [DEPTH-1:0] unpacked  source array.
- start  input  1  single-cycle request to snapshot and scan.
- abort  input  1  terminate an in-progress scan.
- out_valid  output  1  out_data/out_idx/out_last valid.
- out_ready  input  1  consumer accepts the current element.
- out_data  output  WIDTH  current element value.
- out_idx  output  IDX_W  index of the current element.
- out_last  output  1  high while out_idx == DEPTH-1.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse when the scan completes.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE; out_valid, out_last, busy and done are 0; out_idx=0; out_data=0; snapshot cleared to 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at an edge registers all DEPTH elements of arr into the snapshot, sets idx=0 and moves to SCAN.
  - out_valid rises the cycle after start.
- SCAN:
  - out_valid=1; out_data=snapshot[idx]; out_idx=idx; out_last=(idx==DEPTH-1).
  - A transfer occurs on any edge with out_valid & out_ready.
  - On a transfer with idx<DEPTH-1: idx increments.
  - On a transfer with idx==DEPTH-1: go to DONE.
  - With out_ready=0, out_data, out_idx and out_last are held stable and out_valid stays high; no data is dropped.
- DONE: done=1 and out_valid=0 for exactly one cycle, then IDLE; busy drops with the return to IDLE.
- Latency: with out_ready held high, element k transfers k+1 cycles after the start edge and done pulses DEPTH+1 cycles after start.
- start while busy: ignored. The snapshot is not reloaded and the scan is not restarted.
- start and abort in the same IDLE cycle: abort wins and the block stays in IDLE.
- abort in SCAN: next state is IDLE, out_valid=0 from the next cycle, and no done pulse is produced. A transfer in the abort cycle still counts as accepted by the consumer.
- abort in DONE: no effect; the done pulse completes.
- arr changes after the start edge have no effect on the output stream (snapshot semantics).
- ASYNCRESET mid-scan: all outputs return to their reset values immediately, with no done pulse.
- idx never wraps: the transfer at DEPTH-1 always exits SCAN.

Optional Feature:
- Macro: ARRAY_SCAN_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [WIDTH-1:0].
  - The accumulator clears to 0 on an accepted start and XORs in out_data on every transfer.
  - checksum holds its value after DONE until the next accepted start. Reset value is 0.
  - An abort leaves the partial XOR visible on checksum.
- When undefined: the checksum port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Full scan: defaults, arr[i]=i+1, out_ready=1, start pulse at cycle 0.
   - out_data=1..64 on cycles 1..64, with out_idx=0..63.
   - out_last=1 only at out_idx=63; done=1 at cycle 65; busy=0 at cycle 66.
   - With the macro: checksum=8'h40.
2. Backpressure: as scenario 1 but out_ready=0 on cycles 3-5.
   - out_idx=2 and out_data=3 held with out_valid=1 through cycle 5.
   - The stream resumes at cycle 6; done at cycle 68.
3. Snapshot: arr[i]=8'hA5 at start, arr[i] changed to 8'h00 on cycle 1 -> all 64 outputs equal 8'hA5.
4. Abort: abort pulse while out_idx=10 and a transfer is occurring.
   - out_valid=0 and busy=0 on the next cycle; done never asserts.
   - With the macro: checksum = XOR of values at indices 0..10.
5. start ignored while busy: second start pulse at out_idx=20 -> scan continues to 63 unchanged, with exactly one done pulse.
6. Reset mid-scan: ASYNCRESET asserted at out_idx=30.
   - out_valid, busy and done go to 0 immediately.
   - After release, a new start scans again from index 0.

Source files
------------

// File: rtl/array_scan_sequencer.sv
// Snapshots a WIDTH x DEPTH array on start and streams it one element per valid/ready transfer.
// Optional XOR checksum of streamed elements when ARRAY_SCAN_CHECKSUM_EN is defined.
module array_scan_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [WIDTH-1:0] arr [DEPTH-1:0],
  input  logic             start,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
`ifdef ARRAY_SCAN_CHECKSUM_EN
  output logic [WIDTH-1:0] checksum,
`endif
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] snapshot [DEPTH-1:0];

  logic             load_c;
  logic             xfer_c;
  logic             at_last_c;
  logic [IDX_W-1:0] nxt_idx_c;
  logic [IDX_W-1:0] idx_d;
  logic [WIDTH-1:0] data_d;
  logic             valid_d;
  logic             last_d;
  logic             busy_d;
  logic             done_d;

  assign xfer_c    = out_valid & out_ready;
  assign at_last_c = (out_idx == LAST_IDX);

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_d   = state;
    idx_d     = out_idx;
    data_d    = out_data;
    valid_d   = out_valid;
    last_d    = out_last;
    busy_d    = busy;
    done_d    = 1'b0;
    load_c    = 1'b0;
    nxt_idx_c = out_idx + IDX_W'(1);

    case (state)
      IDLE: begin
        // abort takes priority over a coincident start
        if (start && !abort) begin
          load_c  = 1'b1;
          state_d = SCAN;
          idx_d   = '0;
          data_d  = arr[0];
          valid_d = 1'b1;
          last_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (xfer_c) begin
          if (at_last_c) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = nxt_idx_c;
            data_d = snapshot[nxt_idx_c];
            last_d = (nxt_idx_c == LAST_IDX);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state     <= IDLE;
      out_idx   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      out_idx   <= idx_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Snapshot only reloads on an accepted start, so arr may change freely mid-scan.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      for (int i = 0; i < int'(DEPTH); i++) snapshot[i] <= '0;
    end else if (load_c) begin
      for (int i = 0; i < int'(DEPTH); i++) snapshot[i] <= arr[i];
    end
  end

`ifdef ARRAY_SCAN_CHECKSUM_EN
  // Running XOR of accepted elements; a partial value stays visible after abort.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      checksum <= '0;
    end else if (load_c) begin
      checksum <= '0;
    end else if (xfer_c) begin
      checksum <= checksum ^ out_data;
    end
  end
`endif

endmodule
